pcie_cfg_mgmt_arb: RTL and testbench
====================================

Name: pcie_cfg_mgmt_arb

Overview:
Shares the PCIe hard core's single configuration-management port (cfg_mgmt_*) among PORTS internal requesters, for example the host-visible config-access register block and the MSI/FC init sequencer. It uses round-robin arbitration and runs one transaction at a time. Each transaction is held until the core returns read_write_done, with a watchdog that aborts hung accesses. The block sits between fpga_core logic and the pcie4c_uscale_plus core in the pcie_user_clk domain.

Parameters:
PORTS, 2, number of requesters (1..8)
TIMEOUT, 1024, cycles without core done before abort (>=4)

Ports:
clk  in  1  pcie_user_clk, 250 MHz
rst  in  1  synchronous active-high reset
s_cfg_mgmt_addr  in  PORTS*10  per-requester DWORD address, port i at [i*10+:10]
s_cfg_mgmt_function_number  in  PORTS*8  per-requester function
s_cfg_mgmt_write  in  PORTS  write request, held until done
s_cfg_mgmt_write_data  in  PORTS*32  write data
s_cfg_mgmt_byte_enable  in  PORTS*4  byte enables
s_cfg_mgmt_read  in  PORTS  read request, held until done
s_cfg_mgmt_read_data  out  32  shared registered read data, valid with done
s_cfg_mgmt_read_write_done  out  PORTS  one-cycle completion pulse per requester
m_cfg_mgmt_addr  out  10  to core
m_cfg_mgmt_function_number  out  8  to core
m_cfg_mgmt_write  out  1  to core
m_cfg_mgmt_write_data  out  32  to core
m_cfg_mgmt_byte_enable  out  4  to core
m_cfg_mgmt_read  out  1  to core
m_cfg_mgmt_read_data  in  32  from core
m_cfg_mgmt_read_write_done  in  1  from core
busy  out  1  high in ACTIVE and COMPLETE
timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = PORTS-1, so port 0 wins first; watchdog = 0.
- req[i] = s_write[i] | s_read[i].
- States: IDLE, ACTIVE, COMPLETE.
- IDLE transition: at an edge with any req, grant the first requesting port after rr pointer, cyclic. Set rr = grant. Register that port's addr, function, byte_enable, write_data and command. Enter ACTIVE. m_read/m_write are high from the next cycle.
- Write-and-read both set: performed as a write; m_read = 0.
- ACTIVE: master outputs held stable. Watchdog increments each cycle. Requester inputs are ignored, including dropped requests.
- ACTIVE, done sampled at edge m: m_read/m_write = 0 from cycle m+1. s_read_data = m_read_data (captured on reads; writes return 0). s_done[grant] = 1 for cycle m+1 only. Enter COMPLETE.
- ACTIVE, watchdog reaches TIMEOUT-1 with no done: same exit, but s_read_data = 32'hFFFFFFFF and timeout = 1 for one cycle.
- Done and timeout on the same edge: done wins, no timeout pulse.
- COMPLETE: lasts exactly one cycle, the cycle done is visible. Requests are ignored so the finishing requester can deassert on that edge. Then go to IDLE.
- Back-to-back: minimum 3 cycles of master idle gap are not required. The master strobe is low for at least 2 cycles (COMPLETE, IDLE) between transactions.
- Latency: request at edge k gives strobe at k+1. Core done at edge m gives requester done at m+1.
- m_read_write_done outside ACTIVE: ignored.
- Reset mid-ACTIVE: outputs drop next cycle with no done pulse. The core is reset in the same domain.
- PORTS=1 degenerates to a pass-through with one-cycle register and watchdog.

Decomposition:
- Package pcie_cfg_mgmt_pkg holds the state encoding (IDLE=0, ACTIVE=1, COMPLETE=2), the cfg_mgmt field widths (10/8/32/4) and the abort read value 32'hFFFFFFFF.
- Sub-module: rr_arbiter (PORTS-wide request vector in, one-hot plus encoded grant out, pointer update on grant). It is reusable for RQ/CC muxing.

Test Plan:
- Single read, port 0, addr 0x004, core done after 5 cycles with data 0x10EE9038 -> m_read high 5 cycles; s_done[0] one pulse; s_read_data = 0x10EE9038; busy drops after COMPLETE.
- Ports 0 and 1 both request continuously, writes to 0x010/0x020 -> grants alternate 0,1,0,1; no port served twice in a row; strobe gap >= 2 cycles.
- Port 1 write to 0x001, BE=4'b0011, data 0xCAFEF00D -> master fields match exactly; m_write only; s_read_data = 0.
- Core never asserts done, TIMEOUT=16 -> abort after 16 ACTIVE cycles; timeout pulse; s_done pulse; s_read_data = 0xFFFFFFFF; next request served normally.
- Requester drops read mid-ACTIVE; also read+write both set -> transaction completes with done pulse; the dual request is issued as a write.
- rst asserted during ACTIVE -> next cycle all outputs 0, state IDLE; first post-reset grant goes to port 0.

Source files
------------

// File: rtl/pcie_cfg_mgmt_pkg.sv
// Shared definitions for the cfg_mgmt port arbiter: FSM encoding, cfg_mgmt field
// widths and the read value returned when the watchdog aborts an access.
package pcie_cfg_mgmt_pkg;

    localparam int ADDR_W = 10;
    localparam int FUNC_W = 8;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [DATA_W-1:0] ABORT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVE   = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner (cyclic),
// returning both one-hot and encoded grant; the pointer moves only on update.
module rr_arbiter #(
    parameter  int PORTS = 2,
    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             update,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [IDX_W-1:0] ptr;

    // Scan from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int off = PORTS; off >= 1; off--) begin
            if (req[(int'(ptr) + off) % PORTS]) begin
                grant                              = '0;
                grant[(int'(ptr) + off) % PORTS]   = 1'b1;
                grant_idx                          = IDX_W'((int'(ptr) + off) % PORTS);
                valid                              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDX_W'(PORTS - 1);
        end else if (update && valid) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/pcie_cfg_mgmt_arb.sv
// Shares the PCIe core cfg_mgmt port among PORTS requesters, one transaction at a
// time, each held until the core's done or a watchdog abort.
//   state      | meaning
//   S_IDLE     | waiting for any request; arbitrate and latch the winner
//   S_ACTIVE   | command on the core port, waiting for done or watchdog expiry
//   S_COMPLETE | requester done pulse visible; requests ignored for this cycle
module pcie_cfg_mgmt_arb
    import pcie_cfg_mgmt_pkg::*;
#(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS*ADDR_W-1:0] s_cfg_mgmt_addr,
    input  logic [PORTS*FUNC_W-1:0] s_cfg_mgmt_function_number,
    input  logic [PORTS-1:0]        s_cfg_mgmt_write,
    input  logic [PORTS*DATA_W-1:0] s_cfg_mgmt_write_data,
    input  logic [PORTS*BE_W-1:0]   s_cfg_mgmt_byte_enable,
    input  logic [PORTS-1:0]        s_cfg_mgmt_read,
    output logic [DATA_W-1:0]       s_cfg_mgmt_read_data,
    output logic [PORTS-1:0]        s_cfg_mgmt_read_write_done,
    output logic [ADDR_W-1:0]       m_cfg_mgmt_addr,
    output logic [FUNC_W-1:0]       m_cfg_mgmt_function_number,
    output logic                    m_cfg_mgmt_write,
    output logic [DATA_W-1:0]       m_cfg_mgmt_write_data,
    output logic [BE_W-1:0]         m_cfg_mgmt_byte_enable,
    output logic                    m_cfg_mgmt_read,
    input  logic [DATA_W-1:0]       m_cfg_mgmt_read_data,
    input  logic                    m_cfg_mgmt_read_write_done,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    state_t           state, state_nxt;
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [PORTS-1:0] grant_oh;
    logic [WD_W-1:0]  wd;
    logic             start, finish, abort;

    assign req  = s_cfg_mgmt_write | s_cfg_mgmt_read;
    assign busy = (state != S_IDLE);

    rr_arbiter #(.PORTS(PORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .update    (start),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Core done takes priority over a watchdog expiry on the same edge.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    start     = 1'b1;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (m_cfg_mgmt_read_write_done) begin
                    finish    = 1'b1;
                    state_nxt = S_COMPLETE;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = S_COMPLETE;
                end
            end
            S_COMPLETE: state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_cfg_mgmt_addr            <= '0;
            m_cfg_mgmt_function_number <= '0;
            m_cfg_mgmt_write           <= 1'b0;
            m_cfg_mgmt_write_data      <= '0;
            m_cfg_mgmt_byte_enable     <= '0;
            m_cfg_mgmt_read            <= 1'b0;
            s_cfg_mgmt_read_data       <= '0;
            s_cfg_mgmt_read_write_done <= '0;
            timeout                    <= 1'b0;
            grant_oh                   <= '0;
            wd                         <= '0;
        end else begin
            s_cfg_mgmt_read_write_done <= '0;
            timeout                    <= 1'b0;
            if (state == S_ACTIVE) wd <= wd + WD_W'(1);
            if (start) begin
                m_cfg_mgmt_addr            <= s_cfg_mgmt_addr[arb_idx*ADDR_W +: ADDR_W];
                m_cfg_mgmt_function_number <= s_cfg_mgmt_function_number[arb_idx*FUNC_W +: FUNC_W];
                m_cfg_mgmt_write_data      <= s_cfg_mgmt_write_data[arb_idx*DATA_W +: DATA_W];
                m_cfg_mgmt_byte_enable     <= s_cfg_mgmt_byte_enable[arb_idx*BE_W +: BE_W];
                m_cfg_mgmt_write           <= s_cfg_mgmt_write[arb_idx];
                m_cfg_mgmt_read            <= s_cfg_mgmt_read[arb_idx] & ~s_cfg_mgmt_write[arb_idx];
                grant_oh                   <= arb_grant;
                wd                         <= '0;
            end
            if (finish || abort) begin
                m_cfg_mgmt_write           <= 1'b0;
                m_cfg_mgmt_read            <= 1'b0;
                s_cfg_mgmt_read_write_done <= grant_oh;
                timeout                    <= abort;
                s_cfg_mgmt_read_data       <= abort ? ABORT_DATA
                                            : (m_cfg_mgmt_read ? m_cfg_mgmt_read_data : '0);
            end
        end
    end

endmodule

// File: tb/tb_pcie_cfg_mgmt_arb.sv
// Bench for pcie_cfg_mgmt_arb: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pcie_cfg_mgmt_arb;

    localparam int PORTS   = 2;
    localparam int TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [PORTS*10-1:0]  s_addr  = '0;
    logic [PORTS*8-1:0]   s_func  = '0;
    logic [PORTS-1:0]     s_write = '0;
    logic [PORTS*32-1:0]  s_wdata = '0;
    logic [PORTS*4-1:0]   s_be    = '0;
    logic [PORTS-1:0]     s_read  = '0;
    logic [31:0]          s_rdata;
    logic [PORTS-1:0]     s_done;
    logic [9:0]           m_addr;
    logic [7:0]           m_func;
    logic                 m_write;
    logic [31:0]          m_wdata;
    logic [3:0]           m_be;
    logic                 m_read;
    logic [31:0]          m_rdata;
    logic                 m_done;
    logic                 busy;
    logic                 tmo;

    always #5 clk = ~clk;

    pcie_cfg_mgmt_arb #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .s_cfg_mgmt_addr            (s_addr),
        .s_cfg_mgmt_function_number (s_func),
        .s_cfg_mgmt_write           (s_write),
        .s_cfg_mgmt_write_data      (s_wdata),
        .s_cfg_mgmt_byte_enable     (s_be),
        .s_cfg_mgmt_read            (s_read),
        .s_cfg_mgmt_read_data       (s_rdata),
        .s_cfg_mgmt_read_write_done (s_done),
        .m_cfg_mgmt_addr            (m_addr),
        .m_cfg_mgmt_function_number (m_func),
        .m_cfg_mgmt_write           (m_write),
        .m_cfg_mgmt_write_data      (m_wdata),
        .m_cfg_mgmt_byte_enable     (m_be),
        .m_cfg_mgmt_read            (m_read),
        .m_cfg_mgmt_read_data       (m_rdata),
        .m_cfg_mgmt_read_write_done (m_done),
        .busy                       (busy),
        .timeout                    (tmo)
    );

    // Core responder: done after core_delay strobe cycles (0 = never answers).
    int          core_delay = 2;
    logic [31:0] core_data  = '0;
    int          core_n     = 0;
    logic        core_done  = 1'b0;
    logic        spur_done  = 1'b0;
    assign m_done  = core_done | spur_done;
    assign m_rdata = core_data;

    always @(negedge clk) begin
        if (m_read || m_write) begin
            core_n++;
            core_done = (core_delay != 0) && (core_n == core_delay);
        end else begin
            core_n    = 0;
            core_done = 1'b0;
        end
    end

    // Reference model: one transaction in flight, then one completion cycle, then idle.
    int          cur = -1, last = PORTS - 1, hi = 0, w;
    bit          finishing = 0, cur_rd = 0;
    logic        e_rd = 0, e_wr = 0, e_busy = 0, e_tmo = 0;
    logic [PORTS-1:0] e_done = '0;
    logic [31:0] e_rdata = '0, e_wdata = '0;
    logic [9:0]  e_addr = '0;
    logic [7:0]  e_func = '0;
    logic [3:0]  e_be = '0;

    always @(posedge clk) begin
        e_done = '0;
        e_tmo  = 1'b0;
        if (rst) begin
            cur = -1; finishing = 0; last = PORTS - 1; hi = 0;
            e_rd = 0; e_wr = 0; e_busy = 0; e_rdata = '0;
        end else if (cur >= 0) begin
            hi++;
            if (m_done || hi == TIMEOUT) begin
                e_done[cur] = 1'b1;
                e_tmo       = !m_done;
                e_rdata     = m_done ? (cur_rd ? m_rdata : 32'h0) : 32'hFFFF_FFFF;
                e_rd = 0; e_wr = 0; cur = -1; finishing = 1;
            end
        end else if (finishing) begin
            finishing = 0;
            e_busy    = 0;
        end else begin
            w = -1;
            for (int off = 1; off <= PORTS; off++)
                if (w < 0 && (s_read[(last + off) % PORTS] || s_write[(last + off) % PORTS]))
                    w = (last + off) % PORTS;
            if (w >= 0) begin
                cur = w; last = w; hi = 0;
                cur_rd  = s_read[w] && !s_write[w];
                e_rd    = cur_rd;
                e_wr    = s_write[w];
                e_addr  = s_addr[w*10 +: 10];
                e_func  = s_func[w*8 +: 8];
                e_wdata = s_wdata[w*32 +: 32];
                e_be    = s_be[w*4 +: 4];
                e_busy  = 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Observations used by the directed checks.
    bit          prev_strobe = 0, seen_fall = 0;
    int          strobe_run = 0, low_run = 0, last_strobe_len = 0, min_gap = 999;
    int          done_count = 0, last_done_port = -1, tmo_count = 0;
    int          done_log[16];
    logic [9:0]  cap_addr;
    logic [7:0]  cap_func;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_rd, cap_wr;

    task automatic compare_cycle();
        check("busy", busy, e_busy);
        check("m_read", m_read, e_rd);
        check("m_write", m_write, e_wr);
        check("s_done", s_done, e_done);
        check("timeout", tmo, e_tmo);
        check("s_read_data", s_rdata, e_rdata);
        if (e_rd || e_wr) begin
            check("m_addr", m_addr, e_addr);
            check("m_func", m_func, e_func);
            check("m_write_data", m_wdata, e_wdata);
            check("m_byte_enable", m_be, e_be);
        end
    endtask

    task automatic monitor_cycle();
        if (m_read || m_write) begin
            if (!prev_strobe) begin
                cap_addr = m_addr; cap_func = m_func; cap_wdata = m_wdata;
                cap_be = m_be; cap_rd = m_read; cap_wr = m_write;
                if (seen_fall && low_run < min_gap) min_gap = low_run;
            end
            strobe_run++;
        end else begin
            if (prev_strobe) begin
                last_strobe_len = strobe_run;
                strobe_run = 0; low_run = 0; seen_fall = 1;
            end
            low_run++;
        end
        prev_strobe = m_read || m_write;
        for (int p = 0; p < PORTS; p++) begin
            if (s_done[p]) begin
                done_log[done_count % 16] = p;
                last_done_port = p;
                done_count++;
            end
        end
        if (tmo) tmo_count++;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        monitor_cycle();
        #1;
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr, input logic [9:0] a,
                           input logic [7:0] f, input logic [31:0] d, input logic [3:0] be);
        s_read[p]        = rd;
        s_write[p]       = wr;
        s_addr[p*10 +: 10] = a;
        s_func[p*8 +: 8]   = f;
        s_wdata[p*32 +: 32] = d;
        s_be[p*4 +: 4]      = be;
    endtask

    task automatic wait_done(input int p, input int limit);
        int n = 0;
        while (!s_done[p] && n < limit) begin
            step();
            n++;
        end
        check($sformatf("done_port%0d_within_bound", p), s_done[p], 1'b1);
    endtask

    task automatic wait_strobe(input int limit);
        int n = 0;
        while (!(m_read || m_write) && n < limit) begin
            step();
            n++;
        end
        check("strobe_within_bound", m_read || m_write, 1'b1);
    endtask

    int base, tbase;

    initial begin
        // Reset state
        repeat (3) step();
        check("reset_busy", busy, 1'b0);
        check("reset_strobe", {m_read, m_write}, 2'b00);
        check("reset_done", s_done, 2'b00);
        rst = 1'b0;
        step();

        // Single read on port 0, core answers after 5 cycles
        core_delay = 5; core_data = 32'h10EE9038;
        set_req(0, 1, 0, 10'h004, 8'h00, 32'h0, 4'hF);
        wait_done(0, 60);
        check("t1_rdata", s_rdata, 32'h10EE9038);
        check("t1_strobe_len", last_strobe_len, 5);
        check("t1_done_port", last_done_port, 0);
        check("t1_busy_in_complete", busy, 1'b1);
        set_req(0, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        step();
        check("t1_busy_after_complete", busy, 1'b0);

        // Port 1 write: fields pass through, write returns zero data
        core_delay = 3; core_data = 32'hDEADBEEF;
        set_req(1, 0, 1, 10'h001, 8'h02, 32'hCAFEF00D, 4'b0011);
        wait_done(1, 60);
        check("t3_addr", cap_addr, 10'h001);
        check("t3_func", cap_func, 8'h02);
        check("t3_wdata", cap_wdata, 32'hCAFEF00D);
        check("t3_be", cap_be, 4'b0011);
        check("t3_cmd", {cap_rd, cap_wr}, 2'b01);
        check("t3_rdata", s_rdata, 32'h0);
        check("t3_done_port", last_done_port, 1);
        set_req(1, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        step();

        // Both ports request continuously: grants alternate, gap of 2 idle cycles
        core_delay = 2; min_gap = 999; base = done_count;
        set_req(0, 0, 1, 10'h010, 8'h00, 32'h11111111, 4'hF);
        set_req(1, 0, 1, 10'h020, 8'h01, 32'h22222222, 4'hF);
        for (int n = 0; n < 200 && done_count < base + 4; n++) step();
        s_write = '0;
        check("t2_done_count", done_count - base, 4);
        check("t2_grant0", done_log[base % 16], 0);
        check("t2_grant1", done_log[(base + 1) % 16], 1);
        check("t2_grant2", done_log[(base + 2) % 16], 0);
        check("t2_grant3", done_log[(base + 3) % 16], 1);
        check("t2_min_gap", min_gap, 2);
        step();

        // Watchdog abort, then a normal transaction afterwards
        core_delay = 0; tbase = tmo_count;
        set_req(0, 1, 0, 10'h03F, 8'h00, 32'h0, 4'hF);
        wait_done(0, 60);
        check("t4_timeout_pulse", tmo, 1'b1);
        check("t4_strobe_len", last_strobe_len, TIMEOUT);
        check("t4_rdata", s_rdata, 32'hFFFFFFFF);
        set_req(0, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        step();
        check("t4_timeout_count", tmo_count - tbase, 1);
        core_delay = 3; core_data = 32'h12345678;
        set_req(1, 1, 0, 10'h002, 8'h00, 32'h0, 4'hF);
        wait_done(1, 60);
        check("t4_next_rdata", s_rdata, 32'h12345678);
        check("t4_no_extra_timeout", tmo_count - tbase, 1);
        set_req(1, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        step();

        // Read+write together issued as a write; requester drops mid-transaction
        core_delay = 4; core_data = 32'h55AA55AA;
        set_req(0, 1, 1, 10'h0C0, 8'h03, 32'h01020304, 4'hF);
        wait_strobe(20);
        set_req(0, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        wait_done(0, 60);
        check("t5_cmd", {cap_rd, cap_wr}, 2'b01);
        check("t5_rdata", s_rdata, 32'h0);
        check("t5_strobe_len", last_strobe_len, 4);
        step();
        core_data = 32'h0BADCAFE;
        set_req(1, 1, 0, 10'h0C4, 8'h00, 32'h0, 4'hF);
        wait_strobe(20);
        set_req(1, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        wait_done(1, 60);
        check("t5_drop_rdata", s_rdata, 32'h0BADCAFE);
        step();

        // Core done outside a transaction is ignored
        base = done_count;
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        repeat (2) step();
        check("t6_no_done", done_count - base, 0);
        check("t6_idle", busy, 1'b0);

        // Reset while ACTIVE: everything drops, port 0 wins first afterwards
        core_delay = 0;
        set_req(0, 1, 0, 10'h100, 8'h00, 32'h0, 4'hF);
        wait_strobe(20);
        repeat (3) step();
        rst = 1'b1;
        set_req(0, 0, 0, 10'h0, 8'h0, 32'h0, 4'h0);
        base = done_count;
        step();
        check("t7_rst_strobe", {m_read, m_write}, 2'b00);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_done", s_done, 2'b00);
        check("t7_rst_rdata", s_rdata, 32'h0);
        rst = 1'b0;
        step();
        check("t7_no_done_on_reset", done_count - base, 0);
        core_delay = 2;
        set_req(0, 0, 1, 10'h030, 8'h00, 32'h33333333, 4'hF);
        set_req(1, 0, 1, 10'h040, 8'h00, 32'h44444444, 4'hF);
        for (int n = 0; n < 60 && done_count == base; n++) step();
        check("t7_first_grant", last_done_port, 0);
        s_write = '0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
